// File: rtl/asip_mem_pkg.sv
// Shared definitions for the ASIP memory responder.
// Holds the load/run state encoding, the memory-mapped register addresses,
// the default memory depths and the byte-packing helper.
package asip_mem_pkg;

   typedef enum logic [0:0] {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam logic [15:0] MMIO_BASE = 16'hFFF0;
   localparam logic [15:0] GPIO_ADDR = 16'hFFF0;
   localparam logic [15:0] CYC_ADDR  = 16'hFFF1;

   localparam int IMEM_DEPTH_DEF = 256;
   localparam int DMEM_DEPTH_DEF = 256;

   // Builds the word as it stands once the current byte lands in slot cnt.
   // Slots not yet filled read as zero, so a short final word is zero-padded.
   function automatic logic [23:0] pack_bytes(input logic [1:0] cnt,
                                              input logic [7:0] hi,
                                              input logic [7:0] mid,
                                              input logic [7:0] cur);
      logic [23:0] w;
      case (cnt)
         2'd0:    w = {cur, 8'h00, 8'h00};
         2'd1:    w = {hi, cur, 8'h00};
         2'd2:    w = {hi, mid, cur};
         default: w = 24'h000000;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/asip_mem_responder_byte_packer.sv
// Assembles host bytes into 24-bit words, most significant byte first.
// Ports:
//   clk, rst     clock, async active-high reset
//   clr_i        synchronous clear of the partial word (program reload)
//   valid_i      a byte is accepted this cycle
//   byte_i       the byte
//   last_i       this byte ends the program
//   word         packed word (valid together with word_valid)
//   word_valid   word must be written this cycle
//   last         the accepted byte was the final one
module byte_packer
   import asip_mem_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr_i,
   input  logic        valid_i,
   input  logic [7:0]  byte_i,
   input  logic        last_i,
   output logic [23:0] word,
   output logic        word_valid,
   output logic        last
);

   logic [1:0] cnt_q, cnt_d;
   logic [7:0] hi_q, hi_d;
   logic [7:0] mid_q, mid_d;

   // Output word and next-state for the byte counter and held bytes.
   always_comb begin
      word       = pack_bytes(cnt_q, hi_q, mid_q, byte_i);
      word_valid = valid_i && (last_i || (cnt_q == 2'd2));
      last       = valid_i && last_i;
      cnt_d      = cnt_q;
      hi_d       = hi_q;
      mid_d      = mid_q;
      if (clr_i) begin
         cnt_d = 2'd0;
      end else if (valid_i) begin
         if (last_i || (cnt_q == 2'd2)) begin
            cnt_d = 2'd0;
         end else begin
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd0) begin
               hi_d = byte_i;
            end else begin
               mid_d = byte_i;
            end
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Packer state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= 2'd0;
         hi_q  <= 8'h00;
         mid_q <= 8'h00;
      end else begin
         cnt_q <= cnt_d;
         hi_q  <= hi_d;
         mid_q <= mid_d;
      end
   end

endmodule

// File: rtl/asip_mem_responder.sv
// Instruction/data memory responder for a small ASIP core.
// A host streams the program bytewise into imem while the core is held in
// reset (LOAD); afterwards the core runs (RUN) fetching from imem and
// loading/storing dmem plus two memory-mapped registers.
// Ports:
//   clk, rst                       clock, async active-high reset
//   PC / inst                      fetch address / instruction (combinational)
//   aluRes, rd2, memWrite          data address, store data, store strobe
//   rdMemData                      load data (combinational)
//   cpu_rst                        holds the core in reset during LOAD
//   ld_start, ld_valid, ld_byte,
//   ld_last, ld_ready, ld_ovf      host program-load channel
//   gpio_out                       memory-mapped output register
module asip_mem_responder
   import asip_mem_pkg::*;
#(
   parameter int IMEM_DEPTH = IMEM_DEPTH_DEF,
   parameter int DMEM_DEPTH = DMEM_DEPTH_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] PC,
   output logic [23:0] inst,
   input  logic [15:0] aluRes,
   input  logic [23:0] rd2,
   input  logic        memWrite,
   output logic [23:0] rdMemData,
   output logic        cpu_rst,
   input  logic        ld_start,
   input  logic        ld_valid,
   input  logic [7:0]  ld_byte,
   input  logic        ld_last,
   output logic        ld_ready,
   output logic        ld_ovf,
   output logic [23:0] gpio_out
);

   localparam int IAW = $clog2(IMEM_DEPTH);
   localparam int DAW = $clog2(DMEM_DEPTH);

   logic [23:0] imem [IMEM_DEPTH];
   logic [23:0] dmem [DMEM_DEPTH];

   state_e           state_q, state_d;
   logic [IAW-1:0]   waddr_q, waddr_d;
   logic             ovf_q, ovf_d;
   logic [23:0]      gpio_q, gpio_d;
   logic [23:0]      cyc_q, cyc_d;

   logic             run_s;
   logic             accept_s;
   logic             start_s;
   logic             store_s;
   logic [23:0]      pk_word_s;
   logic             pk_valid_s;
   logic             pk_last_s;

   // Depths are powers of two, so the modulo is the low address bits.
   logic             unused_pc_s;
   assign unused_pc_s = ^PC[15:IAW];

   assign run_s    = (state_q == ST_RUN);
   assign accept_s = ld_valid && !run_s;
   assign start_s  = ld_start && run_s;
   assign store_s  = memWrite && run_s;

   byte_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (start_s),
      .valid_i    (accept_s),
      .byte_i     (ld_byte),
      .last_i     (ld_last),
      .word       (pk_word_s),
      .word_valid (pk_valid_s),
      .last       (pk_last_s)
   );

   // FSM, load address, overflow flag, GPIO and cycle counter next-state.
   always_comb begin
      state_d = state_q;
      waddr_d = waddr_q;
      ovf_d   = ovf_q;
      gpio_d  = gpio_q;
      cyc_d   = 24'h000000;
      case (state_q)
         ST_LOAD: begin
            if (pk_valid_s) begin
               if (waddr_q == IAW'(IMEM_DEPTH - 1)) begin
                  waddr_d = '0;
                  ovf_d   = 1'b1;
               end else begin
                  waddr_d = waddr_q + IAW'(1);
               end
            end else begin
               waddr_d = waddr_q;
            end
            if (pk_last_s) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_LOAD;
            end
         end
         ST_RUN: begin
            // A store coinciding with ld_start still completes.
            if (store_s && (aluRes == GPIO_ADDR)) begin
               gpio_d = rd2;
            end else begin
               gpio_d = gpio_q;
            end
            if (start_s) begin
               state_d = ST_LOAD;
               waddr_d = '0;
               ovf_d   = 1'b0;
               cyc_d   = 24'h000000;
            end else begin
               cyc_d   = cyc_q + 24'd1;
            end
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   // Control registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_LOAD;
         waddr_q <= '0;
         ovf_q   <= 1'b0;
         gpio_q  <= 24'h000000;
         cyc_q   <= 24'h000000;
      end else begin
         state_q <= state_d;
         waddr_q <= waddr_d;
         ovf_q   <= ovf_d;
         gpio_q  <= gpio_d;
         cyc_q   <= cyc_d;
      end
   end

   // Memory arrays keep their contents across reset.
   always_ff @(posedge clk) begin
      if (pk_valid_s) begin
         imem[waddr_q] <= pk_word_s;
      end
      if (store_s && (aluRes < MMIO_BASE)) begin
         dmem[aluRes[DAW-1:0]] <= rd2;
      end
   end

   // Combinational fetch and load paths; both read zero while loading.
   always_comb begin
      inst      = 24'h000000;
      rdMemData = 24'h000000;
      if (run_s) begin
         inst = imem[PC[IAW-1:0]];
         if (aluRes < MMIO_BASE) begin
            rdMemData = dmem[aluRes[DAW-1:0]];
         end else if (aluRes == GPIO_ADDR) begin
            rdMemData = gpio_q;
         end else if (aluRes == CYC_ADDR) begin
            rdMemData = cyc_q;
         end else begin
            rdMemData = 24'h000000;
         end
      end else begin
         inst      = 24'h000000;
         rdMemData = 24'h000000;
      end
   end

   assign cpu_rst  = !run_s;
   assign ld_ready = !run_s;
   assign ld_ovf   = ovf_q;
   assign gpio_out = gpio_q;

endmodule
